riscv_core_me_branch_unit: RTL
==============================

Name: riscv_core_me_branch_unit

Overview:
- Parametrised successor to the memory-stage PC-source logic.
- Resolves all six RV32/64 conditional branches and unconditional jumps in the ME stage from full operands, rather than from a single zero flag.
- Compares each outcome against a bimodal branch-history-table (BHT) prediction, which it also serves to fetch.
- On a mispredict it drives PC redirect and a multi-cycle flush sequence.

Parameters:
- XLEN, 32: operand/PC width (32 or 64).
- BHT_DEPTH, 64: number of 2-bit counters; power of two, 4..1024.
- FLUSH_CYCLES, 2: cycles s_me_flush_D stays high after a mispredict; 1..7.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- ACT  in  1  ME stage holds a valid instruction this cycle.
- r_me_branchop_Q  in  3  0 none, 1 jump, 2 BNE, 3 BEQ, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
- r_me_src1_Q  in  XLEN  rs1 value.
- r_me_src2_Q  in  XLEN  rs2 value.
- r_me_pc_Q  in  XLEN  PC of the ME instruction.
- r_me_target_Q  in  XLEN  computed branch/jump target.
- r_me_pred_taken_Q  in  1  prediction that fetch made for this instruction.
- fe_pc_D  in  XLEN  fetch PC for the BHT lookup.
- fe_pred_taken_D  out  1  BHT prediction for fe_pc_D.
- s_me_pcsrc_D  out  1  redirect fetch this cycle.
- s_me_redirect_pc_D  out  XLEN  redirect address.
- s_me_flush_D  out  1  kill the younger in-flight stages.
- perf_clr  in  1  synchronous clear of the performance counters.
- perf_branch_cnt_Q  out  CNT_W  resolved conditional branches.
- perf_mispred_cnt_Q  out  CNT_W  mispredicts.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM goes to IDLE; flush counter is 0.
  - Every BHT entry is set to 2'b01 (weakly not-taken).
  - Perf counters are 0.
  - All outputs are 0, except fe_pred_taken_D, which reads 0 from the reset BHT.
- Condition evaluation (combinational):
  - EQ/NE compare the full XLEN bits.
  - LT/GE compare signed; LTU/GEU compare unsigned.
  - Jump (op 1) is always taken. Op 0 is never a branch.
- valid_br = ACT and state==IDLE and op!=0.
- mispred = valid_br and (taken != r_me_pred_taken_Q).
- Redirect outputs (combinational, same cycle T):
  - s_me_pcsrc_D = mispred.
  - s_me_redirect_pc_D = r_me_target_Q when taken, else r_me_pc_Q+4, with wrap modulo 2^XLEN.
  - s_me_redirect_pc_D is 0 when mispred=0.
- FSM, two states:
  - IDLE: on mispred at T, go to FLUSH and load the counter with FLUSH_CYCLES-1.
  - FLUSH: s_me_flush_D=1 for exactly cycles T+1..T+FLUSH_CYCLES. The counter decrements each cycle; return to IDLE when it reads 0.
  - While in FLUSH, ACT is ignored: no resolution, no pcsrc, no BHT update, no perf count. The ME instruction is a flushed bubble.
  - A mispredict in the first IDLE cycle after FLUSH is legal and starts a new sequence back-to-back.
- BHT index = pc[log2(BHT_DEPTH)+1:2]. Lookup is combinational.
- fe_pred_taken_D = entry[fe_pc_D index][1]. Read-during-write returns the pre-update value.
- BHT update:
  - Applies only when valid_br and op>=2; jumps never update.
  - Saturating 2-bit counter: increment when taken (cap 3), decrement when not taken (floor 0).
  - Written at the T→T+1 edge. The update happens regardless of mispred.
- Reset asserted mid-FLUSH aborts the sequence immediately: s_me_flush_D drops asynchronously and the BHT is reinitialised.

Optional Feature:
- Macro: BRANCH_PERF_EN.
- Defined:
  - perf_branch_cnt_Q increments on each valid_br with op>=2.
  - perf_mispred_cnt_Q increments on each mispred, jumps included.
  - Both counters saturate at 2^CNT_W-1.
  - perf_clr=1 zeroes both at the next edge; the clear wins over a simultaneous increment.
- Undefined: no counter flops; both perf outputs are tied to 0 and perf_clr is ignored. Ports stay present.

Test Plan:
- Branch resolution: after reset, ACT=1, op=3 (BEQ), src1=src2=0x1234, pc=0x100, target=0x180, pred=0
  -> cycle T: pcsrc=1, redirect=0x180.
  -> flush=1 for exactly 2 cycles.
  -> BHT[0x100 idx] becomes 2'b10; fe_pc_D=0x100 then yields pred=1.
- Signed vs unsigned: src1=0xFFFFFFFF, src2=0x1, pred=0.
  -> op 4 (BLT): taken, mispred, pcsrc=1.
  -> op 6 (BLTU): not taken, no pcsrc, BHT entry decrements to 2'b00.
- Fall-through redirect: op=2 (BNE), equal operands, pred=1, pc=0xFFFFFFFC
  -> redirect=0x00000000 (wrap), pcsrc=1.
- Flush suppression and back-to-back: mispredict, then in both FLUSH cycles present op=3 with mispredicting values
  -> no pcsrc, BHT unchanged.
  -> a mispredict in the first IDLE cycle after the flush restarts FLUSH.
- Async reset: assert RST=0 mid-FLUSH after training BHT entry 5 to 2'b11
  -> flush=0 immediately, FSM IDLE, fe_pred_taken_D for entry 5 = 0.
- Perf counters (BRANCH_PERF_EN, CNT_W=4): 20 mispredicting BEQs
  -> both counters hold 15.
  -> perf_clr asserted together with another branch -> both read 0 next cycle.
- Perf counters (without macro): same stimulus -> both counters remain 0.

Source files
------------

// File: rtl/riscv_core_me_branch_unit_if.sv
// ME-stage branch unit bus: instruction operands, BHT lookup and redirect/flush outputs.
// The master side is the pipeline; the slave side is riscv_core_me_branch_unit.
interface riscv_core_me_branch_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             ACT;
  logic [2:0]       r_me_branchop_Q;
  logic [XLEN-1:0]  r_me_src1_Q;
  logic [XLEN-1:0]  r_me_src2_Q;
  logic [XLEN-1:0]  r_me_pc_Q;
  logic [XLEN-1:0]  r_me_target_Q;
  logic             r_me_pred_taken_Q;
  logic [XLEN-1:0]  fe_pc_D;
  logic             fe_pred_taken_D;
  logic             s_me_pcsrc_D;
  logic [XLEN-1:0]  s_me_redirect_pc_D;
  logic             s_me_flush_D;
  logic             perf_clr;
  logic [CNT_W-1:0] perf_branch_cnt_Q;
  logic [CNT_W-1:0] perf_mispred_cnt_Q;

  modport master (
    output ACT, r_me_branchop_Q, r_me_src1_Q, r_me_src2_Q, r_me_pc_Q,
           r_me_target_Q, r_me_pred_taken_Q, fe_pc_D, perf_clr,
    input  fe_pred_taken_D, s_me_pcsrc_D, s_me_redirect_pc_D, s_me_flush_D,
           perf_branch_cnt_Q, perf_mispred_cnt_Q
  );

  modport slave (
    input  ACT, r_me_branchop_Q, r_me_src1_Q, r_me_src2_Q, r_me_pc_Q,
           r_me_target_Q, r_me_pred_taken_Q, fe_pc_D, perf_clr,
    output fe_pred_taken_D, s_me_pcsrc_D, s_me_redirect_pc_D, s_me_flush_D,
           perf_branch_cnt_Q, perf_mispred_cnt_Q
  );
endinterface

// File: rtl/riscv_core_me_branch_unit.sv
// ME-stage branch resolution with a bimodal BHT, mispredict redirect and multi-cycle flush.
// Define BRANCH_PERF_EN to build the saturating branch/mispredict performance counters.
module riscv_core_me_branch_unit #(
  parameter int XLEN         = 32,
  parameter int BHT_DEPTH    = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                    CLK,
  input logic                    RST,
  riscv_core_me_branch_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_cur, bht_d;
  logic             taken;
  logic             valid_br;
  logic             mispred;
  logic             bht_upd;
  logic [IDX_W-1:0] me_idx;
  logic [IDX_W-1:0] fe_idx;
  logic             unused_fe;

  always_comb begin
    taken = 1'b0;
    unique case (bus.r_me_branchop_Q)
      3'd1: taken = 1'b1;
      3'd2: taken = (bus.r_me_src1_Q != bus.r_me_src2_Q);
      3'd3: taken = (bus.r_me_src1_Q == bus.r_me_src2_Q);
      3'd4: taken = ($signed(bus.r_me_src1_Q) <  $signed(bus.r_me_src2_Q));
      3'd5: taken = ($signed(bus.r_me_src1_Q) >= $signed(bus.r_me_src2_Q));
      3'd6: taken = (bus.r_me_src1_Q <  bus.r_me_src2_Q);
      3'd7: taken = (bus.r_me_src1_Q >= bus.r_me_src2_Q);
      default: taken = 1'b0;
    endcase
  end

  // Gating with RST keeps the combinational redirect quiet while reset is held.
  assign valid_br = RST && bus.ACT && (state_q == IDLE) && (bus.r_me_branchop_Q != 3'd0);
  assign mispred  = valid_br && (taken != bus.r_me_pred_taken_Q);
  assign bht_upd  = valid_br && (bus.r_me_branchop_Q[2] || bus.r_me_branchop_Q[1]);

  assign bus.s_me_pcsrc_D       = mispred;
  assign bus.s_me_redirect_pc_D = !mispred ? '0 :
                                  taken    ? bus.r_me_target_Q :
                                             bus.r_me_pc_Q + XLEN'(4);
  assign bus.s_me_flush_D       = (state_q == FLUSH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mispred) begin
          state_d = FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign me_idx    = bus.r_me_pc_Q[IDX_W+1:2];
  assign fe_idx    = bus.fe_pc_D[IDX_W+1:2];
  assign unused_fe = ^{bus.fe_pc_D[XLEN-1:IDX_W+2], bus.fe_pc_D[1:0]};

  assign bus.fe_pred_taken_D = bht_q[fe_idx][1];

  always_comb begin
    bht_cur = bht_q[me_idx];
    bht_d   = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (bht_upd) begin
      bht_q[me_idx] <= bht_d;
    end
  end

`ifdef BRANCH_PERF_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  // Clear has priority over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (bus.perf_clr) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (bht_upd && !(&br_cnt_q))  br_cnt_q  <= br_cnt_q + 1'b1;
      if (mispred && !(&mis_cnt_q)) mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign bus.perf_branch_cnt_Q  = br_cnt_q;
  assign bus.perf_mispred_cnt_Q = mis_cnt_q;
`else
  logic unused_perf;

  assign unused_perf            = bus.perf_clr;
  assign bus.perf_branch_cnt_Q  = {CNT_W{1'b0}};
  assign bus.perf_mispred_cnt_Q = {CNT_W{1'b0}};
`endif

endmodule
